// File: rtl/sha256_uart_sequencer.sv
// rtl/sha256_uart_sequencer.sv - UART byte-stream front end that loads, starts and reads back the sha256 core
module sha256_uart_sequencer #(
    parameter logic [3:0] CMD_WRITE  = 4'h1,
    parameter logic [3:0] CMD_FIRST  = 4'h2,
    parameter logic [3:0] CMD_NEXT   = 4'h3,
    parameter logic [3:0] CMD_READ   = 4'h4,
    parameter int         READ_LAT   = 2,
    parameter int         RX_TIMEOUT = 2**20,
    parameter int         BUSY_WAIT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_error,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    output logic [31:0] core_text_o,
    input  logic [31:0] core_text_i,
    output logic [3:0]  core_cmd,
    output logic        core_cmd_w,
    input  logic        core_busy,
    output logic        busy,
    output logic [7:0]  status
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] LOAD    = 4'd1;
    localparam logic [3:0] WRITE   = 4'd2;
    localparam logic [3:0] START   = 4'd3;
    localparam logic [3:0] WAIT_HI = 4'd4;
    localparam logic [3:0] WAIT_LO = 4'd5;
    localparam logic [3:0] READ    = 4'd6;
    localparam logic [3:0] CAPTURE = 4'd7;
    localparam logic [3:0] TX_LOAD = 4'd8;
    localparam logic [3:0] TX_WAIT = 4'd9;
    localparam logic [3:0] ERR     = 4'd10;

    localparam int TO_W = $clog2(RX_TIMEOUT + 1);
    localparam int BW_W = $clog2(BUSY_WAIT + 1);

    logic [3:0]      state;
    logic [3:0]      err_code;
    logic [31:0]     acc;
    logic [1:0]      byte_cnt;
    logic [3:0]      word_cnt;
    logic            is_first;
    logic [TO_W-1:0] to_cnt;
    logic [BW_W-1:0] bw_cnt;
    logic [2:0]      rd_cnt;
    logic [1:0]      lat_cnt;
    logic [31:0]     tx_data;
    logic [2:0]      tx_left;
    logic            tx_err;
    logic [1:0]      tx_guard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            err_code <= 4'd0;
            acc      <= 32'd0;
            byte_cnt <= 2'd0;
            word_cnt <= 4'd0;
            is_first <= 1'b0;
            to_cnt   <= '0;
            bw_cnt   <= '0;
            rd_cnt   <= 3'd0;
            lat_cnt  <= 2'd0;
            tx_data  <= 32'd0;
            tx_left  <= 3'd0;
            tx_err   <= 1'b0;
            tx_guard <= 2'd0;
            tx_start <= 1'b0;
            tx_byte  <= 8'd0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
                            is_first <= (rx_byte == 8'h01);
                            err_code <= 4'd0;
                            byte_cnt <= 2'd0;
                            word_cnt <= 4'd0;
                            to_cnt   <= '0;
                            state    <= LOAD;
                        end else begin
                            err_code <= 4'd1;
                            state    <= ERR;
                        end
                    end
                end
                LOAD: begin
                    if (rx_error) begin
                        err_code <= 4'd2;
                        state    <= ERR;
                    end else if (rx_valid) begin
                        acc      <= {acc[23:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        to_cnt   <= '0;
                        if (byte_cnt == 2'd3) state <= WRITE;
                    end else if (to_cnt == TO_W'(RX_TIMEOUT - 1)) begin
                        err_code <= 4'd4;
                        state    <= ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 4'd1;
                    if (rx_error) begin
                        err_code <= 4'd2;
                        state    <= ERR;
                    end else begin
                        state <= (word_cnt == 4'd15) ? START : LOAD;
                    end
                end
                START: begin
                    bw_cnt <= '0;
                    state  <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (core_busy) begin
                        state <= WAIT_LO;
                    end else if (bw_cnt == BW_W'(BUSY_WAIT)) begin
                        err_code <= 4'd3;
                        state    <= ERR;
                    end else begin
                        bw_cnt <= bw_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!core_busy) begin
                        rd_cnt <= 3'd0;
                        state  <= READ;
                    end
                end
                READ: begin
                    lat_cnt <= 2'd0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    if (lat_cnt == 2'(READ_LAT - 1)) begin
                        tx_data <= core_text_i;
                        tx_left <= 3'd4;
                        tx_err  <= 1'b0;
                        state   <= TX_LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                TX_LOAD: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_byte  <= tx_data[31:24];
                        tx_data  <= {tx_data[23:0], 8'h00};
                        tx_left  <= tx_left - 3'd1;
                        tx_guard <= 2'd2;
                        state    <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    // The transmitter may not raise tx_busy until after it registers tx_start.
                    if (tx_guard != 2'd0) begin
                        tx_guard <= tx_guard - 2'd1;
                    end else if (!tx_busy) begin
                        if (tx_left != 3'd0) begin
                            state <= TX_LOAD;
                        end else if (tx_err || rd_cnt == 3'd7) begin
                            state <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + 3'd1;
                            state  <= READ;
                        end
                    end
                end
                ERR: begin
                    tx_data <= {8'hEE, 24'h0};
                    tx_left <= 3'd1;
                    tx_err  <= 1'b1;
                    state   <= TX_LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        core_cmd_w  = 1'b0;
        core_cmd    = 4'd0;
        core_text_o = 32'd0;
        case (state)
            WRITE: begin
                core_cmd_w  = 1'b1;
                core_cmd    = CMD_WRITE;
                core_text_o = acc;
            end
            START: begin
                core_cmd_w = 1'b1;
                core_cmd   = is_first ? CMD_FIRST : CMD_NEXT;
            end
            READ: begin
                core_cmd_w = 1'b1;
                core_cmd   = CMD_READ;
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign status = {state, err_code};

endmodule
